// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and latency helpers for the HI/LO multiply/divide unit
package mdu_pkg;
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} mdu_state_e;
  localparam int MDU_W   = 32;
  localparam int DIV_LAT = MDU_W + 1;
  function automatic int div_lat(input int w);
    return w + 1;
  endfunction
endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: iterative unsigned radix-2 restoring divider, one quotient bit per clock
// Ports: clk, resetn (sync active-low); start_i loads dividend_i/divisor_i; flush_i aborts;
//        quotient_o/remainder_o hold the result while valid_o is high (set after W iterations).
module mdu_div_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start_i,
  input  logic         flush_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o,
  output logic         valid_o
);
  localparam int CW = $clog2(W + 2);
  logic [W-1:0]  quo_q, rem_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic          run_q, valid_q;
  logic [W:0]    sh, trial;
  // trial[W] set means the shifted remainder was below the divisor: restore
  assign sh    = {rem_q, quo_q[W-1]};
  assign trial = sh - {1'b0, dvs_q};
  always_ff @(posedge clk) begin
    if (!resetn) begin
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (start_i) begin
      quo_q   <= dividend_i;
      rem_q   <= '0;
      dvs_q   <= divisor_i;
      cnt_q   <= '0;
      run_q   <= 1'b1;
      valid_q <= 1'b0;
    end else if (run_q) begin
      rem_q   <= trial[W] ? sh[W-1:0] : trial[W-1:0];
      quo_q   <= {quo_q[W-2:0], ~trial[W]};
      cnt_q   <= cnt_q + 1'b1;
      run_q   <= cnt_q != CW'(W - 1);
      valid_q <= cnt_q == CW'(W - 1);
    end
  end
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign valid_o     = valid_q;
endmodule

// File: rtl/mdu_hilo_unit.sv
// mdu_hilo_unit: multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO register pair
// Ports: clk, resetn (sync active-low); start_i/op_i/a_i/b_i issue an operation; mt_we_i/mt_hi_i/mt_data_i
//        write HI or LO directly; flush_i aborts; stall_o holds the pipeline; busy_o = not IDLE;
//        done_o pulses the cycle a new result appears on hi_o/lo_o.
module mdu_hilo_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              mt_we_i,
  input  logic              mt_hi_i,
  input  logic [DATA_W-1:0] mt_data_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  localparam int CW = $clog2(DATA_W + 2);
  localparam int DL = div_lat(DATA_W);
  mdu_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, b_q, hi_q, hi_d, lo_q, lo_d;
  logic                sgn_q, done_q, done_d, accept;
  logic                a_neg, b_neg, dv_valid;
  logic [DATA_W-1:0]   quo, rem, q_fix, r_fix;
  logic [2*DATA_W-1:0] ax, bx, prod;
  assign accept = state_q == IDLE && start_i && !flush_i;
  // sign-extending (or zero-extending) to full width makes one multiplier serve both MULT and MULTU
  assign ax     = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
  assign bx     = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
  assign prod   = ax * bx;
  assign a_neg  = sgn_q & a_q[DATA_W-1];
  assign b_neg  = sgn_q & b_q[DATA_W-1];
  assign q_fix  = (b_q == '0) ? '1 : ((a_neg ^ b_neg) ? -quo : quo);
  assign r_fix  = (b_q == '0) ? a_q : (a_neg ? -rem : rem);
  mdu_div_core #(.W(DATA_W)) u_div (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (accept && op_i[1]),
    .flush_i    (flush_i),
    .dividend_i ((!op_i[0] && a_i[DATA_W-1]) ? -a_i : a_i),
    .divisor_i  ((!op_i[0] && b_i[DATA_W-1]) ? -b_i : b_i),
    .quotient_o (quo),
    .remainder_o(rem),
    .valid_o    (dv_valid)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = op_i[1] ? DIV : MUL;
          cnt_d   = CW'(1);
        end else if (mt_we_i && !start_i) begin
          hi_d = mt_hi_i ? mt_data_i : hi_q;
          lo_d = mt_hi_i ? lo_q : mt_data_i;
        end
      end
      MUL: begin
        if (flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(MUL_LAT)) begin
          state_d      = IDLE;
          cnt_d        = '0;
          {hi_d, lo_d} = prod;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DIV: begin
        state_d = flush_i ? IDLE : (cnt_q == CW'(DL - 1) ? FIX : DIV);
        cnt_d   = (flush_i || cnt_q == CW'(DL - 1)) ? '0 : cnt_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        if (!flush_i && dv_valid) begin
          hi_d   = r_fix;
          lo_d   = q_fix;
          done_d = 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= accept ? a_i : a_q;
      b_q     <= accept ? b_i : b_q;
      sgn_q   <= accept ? !op_i[0] : sgn_q;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign busy_o  = state_q != IDLE;
  assign stall_o = (state_q == IDLE && start_i) || busy_o;
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
`ifndef SYNTHESIS
  // the hazard unit must keep MTHI/MTLO away from a busy unit and from a same-cycle start
  a_mt_idle: assert property (@(posedge clk) disable iff (!resetn) mt_we_i |-> (state_q == IDLE && !start_i))
    else $error("mdu_hilo_unit: MTHI/MTLO dropped");
`endif
endmodule

// File: tb/tb_mdu_hilo_unit.sv
// tb_mdu_hilo_unit: randomized and directed self-checking bench against an arithmetic HI/LO model
module tb_mdu_hilo_unit;
  localparam int W = 32, LAT = 4;
  logic         clk = 0, resetn = 0, start_i = 0, mt_we_i = 0, mt_hi_i = 0, flush_i = 0;
  logic [1:0]   op_i = 0;
  logic [W-1:0] a_i = 0, b_i = 0, mt_data_i = 0;
  logic         stall_o, busy_o, done_o;
  logic [W-1:0] hi_o, lo_o;
  logic [W-1:0] m_hi = 0, m_lo = 0;
  int           total = 0, bad = 0;
  always #5 clk = ~clk;
  mdu_hilo_unit #(.DATA_W(W), .MUL_LAT(LAT)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .mt_we_i(mt_we_i), .mt_hi_i(mt_hi_i), .mt_data_i(mt_data_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (op == 2'd0) return longint'(sa) * longint'(sb);
    if (op == 2'd1) return {32'd0, a} * {32'd0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (op == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    if (op == 2'd2) return {32'(sa % sb), 32'(sa / sb)};
    return {a % b, a / b};
  endfunction
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int n, st, lat;
    e   = ref_op(op, a, b);
    lat = op[1] ? W + 2 : LAT + 1;
    n   = 0;
    @(negedge clk);
    start_i = 1; op_i = op; a_i = a; b_i = b;
    #1 st = int'(stall_o);
    do begin
      @(negedge clk);
      start_i = 0;
      #1 n++;
      if (stall_o) st++;
    end while (!done_o && n < 60);
    check($sformatf("latency op%0d", op), n, lat);
    check($sformatf("stall_cycles op%0d", op), st, lat);
    check($sformatf("hi op%0d a=%h b=%h", op, a, b), hi_o, e[63:32]);
    check($sformatf("lo op%0d a=%h b=%h", op, a, b), lo_o, e[31:0]);
    m_hi = e[63:32];
    m_lo = e[31:0];
    @(negedge clk);
    #1 check("done_single_pulse", done_o, 0);
  endtask
  task automatic mt_write(input logic hi, input logic [31:0] d);
    @(negedge clk);
    mt_we_i = 1; mt_hi_i = hi; mt_data_i = d;
    @(negedge clk);
    mt_we_i = 0;
    if (hi) m_hi = d;
    else m_lo = d;
    #1 check("mt_hi", hi_o, m_hi);
    check("mt_lo", lo_o, m_lo);
  endtask
  task automatic abort_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int k, input logic rst);
    int dn;
    dn = 0;
    @(negedge clk);
    start_i = 1; op_i = op; a_i = a; b_i = b;
    repeat (k) begin
      @(negedge clk);
      start_i = 0;
      dn += int'(done_o);
    end
    if (rst) resetn = 0;
    else flush_i = 1;
    @(negedge clk);
    resetn = 1; flush_i = 0;
    if (rst) begin
      m_hi = 0;
      m_lo = 0;
    end
    #1 check("abort_busy", busy_o, 0);
    check("abort_stall", stall_o, 0);
    check("abort_hi", hi_o, m_hi);
    check("abort_lo", lo_o, m_lo);
    repeat (40) begin
      dn += int'(done_o);
      @(negedge clk);
    end
    check("abort_no_done", dn, 0);
    check("abort_hi_later", hi_o, m_hi);
  endtask
  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    #1 check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_stall", stall_o, 0);
    resetn = 1;
    run_op(2'd0, 32'hFFFF_FFFF, 32'h2);
    run_op(2'd1, 32'hFFFF_FFFF, 32'h2);
    run_op(2'd2, 32'hFFFF_FFF9, 32'h2);
    run_op(2'd3, 32'd100, 32'd7);
    run_op(2'd3, 32'h1234_5678, 32'h0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'd2, 32'hFFFF_FFF0, 32'h0);
    mt_write(1'b1, 32'hAAAA_0000);
    abort_op(2'd2, 32'd1000, 32'd3, 10, 1'b0);
    mt_write(1'b0, 32'h5);
    abort_op(2'd0, 32'h1234, 32'h5678, LAT, 1'b0);
    abort_op(2'd3, 32'd999, 32'd4, W + 1, 1'b0);
    @(negedge clk);
    start_i = 1; flush_i = 1; op_i = 2'd3; a_i = 32'd50; b_i = 32'd5;
    @(negedge clk);
    start_i = 0; flush_i = 0;
    #1 check("start_flush_dropped", busy_o, 0);
    check("start_flush_lo", lo_o, m_lo);
    mt_write(1'b1, 32'hDEAD_BEEF);
    abort_op(2'd2, 32'hFFFF_0000, 32'd9, 20, 1'b1);
    repeat (40) begin
      if ($urandom_range(0, 7) < 2) mt_write(1'($urandom_range(0, 1)), $urandom);
      else begin
        op = 2'($urandom_range(0, 3));
        a  = $urandom;
        b  = $urandom;
        case ($urandom_range(0, 7))
          0: b = 0;
          1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
          2: b = $urandom_range(1, 15);
          default: ;
        endcase
        run_op(op, a, b);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu_hilo_unit.md
Name: mdu_hilo_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the MIPS core.
- Executes MULT, MULTU, DIV and DIVU. MULT/MULTU use a fixed-latency multiplier; DIV/DIVU use an iterative radix-2 restoring divider.
- Also accepts MTHI/MTLO direct writes.
- Sits beside the EX stage. The main decoder's HiloWrite/HiloSrc/HilotoReg controls drive its inputs. The hazard unit uses its stall output to freeze the pipeline while an operation is in flight.

Parameters:
- DATA_W, 32, operand, HI and LO width.
- MUL_LAT, 4, cycles from start acceptance to the HI/LO write for multiply; legal range 1..8.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  synchronous active-low reset.
- start_i  in  1  request a mul/div this cycle.
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a_i  in  DATA_W  rs operand.
- b_i  in  DATA_W  rt operand.
- mt_we_i  in  1  MTHI/MTLO write request.
- mt_hi_i  in  1  1 selects HI, 0 selects LO.
- mt_data_i  in  DATA_W  MTHI/MTLO data.
- flush_i  in  1  abort the in-flight operation (exception/ERET).
- stall_o  out  1  pipeline must hold EX and earlier stages.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle pulse when a new HI/LO result first becomes visible.
- hi_o  out  DATA_W  HI register.
- lo_o  out  DATA_W  LO register.

Behaviour:
- Clocking/reset (decided): single clock clk; reset is synchronous, active-low on resetn.
- Reset values: state IDLE, hi_o=0, lo_o=0, done_o=0, busy_o=0. Counters and operand latches are cleared.
- Reset mid-operation discards all work; HI/LO are forced to 0.
- States:
  - IDLE. start_i=1 latches a_i, b_i, op_i. Next state is MUL for op 0x or DIV for op 1x.
  - MUL. Counter runs 1..MUL_LAT. At edge MUL_LAT after acceptance:
    - {HI,LO} <= full 2*DATA_W product, signed for MULT, unsigned for MULTU.
    - Next state IDLE.
  - DIV. Before iterating, operands are converted to magnitudes (signed ops only); signs are recorded.
    - Edges 1..DATA_W: one restoring iteration per edge.
    - Then go to FIX.
  - FIX (edge DATA_W+1). Apply sign correction:
    - Quotient is negated if the operand signs differ.
    - Remainder takes the dividend's sign.
    - Write LO=quotient, HI=remainder. Next state IDLE.
- done_o is registered. It is high exactly in the first cycle after the HI/LO write edge.
- stall_o = (state==IDLE && start_i) || state!=IDLE. It is combinational, so the issuing instruction is held from its first EX cycle.
- Once stall_o drops, the next instruction may read hi_o/lo_o; the result is already committed.
- Divide by zero (b=0): LO = all ones, HI = the original dividend a. Latency is unchanged.
- Signed overflow (INT_MIN / -1): LO=INT_MIN, HI=0. No trap.
- flush_i=1 in any non-IDLE state:
  - Next state is IDLE; HI/LO are not written; done_o stays 0.
  - If flush_i and start_i are both high in IDLE, the start is dropped.
  - If flush_i coincides with the final write edge, the flush wins and no write occurs.
- MTHI/MTLO:
  - In IDLE with mt_we_i=1 and start_i=0, the selected register is written at that edge.
  - mt_we_i while busy is ignored. A simulation assertion flags it; the hazard unit must prevent it.
  - mt_we_i together with start_i in IDLE: start takes priority and mt is dropped (flagged by assertion).
- Widths: the multiply product is 2*DATA_W wide. The divider partial remainder is DATA_W+1 wide. The counter is $clog2(DATA_W+2) bits.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings MDU_MULT/MULTU/DIV/DIVU;
  - state enum IDLE/MUL/DIV/FIX;
  - DIV_LAT = DATA_W+1 helper constant.
- One natural sub-module, mdu_div_core: the iterative unsigned restoring divider.
  - Interface: start, dividend, divisor, flush; outputs quotient, remainder, valid.
  - Sign handling stays in the parent.

Test Plan:
- MULT a=0xFFFFFFFF, b=0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE. done_o in cycle MUL_LAT+1; stall_o high for MUL_LAT+1 cycles.
- MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, done_o at cycle 34. DIVU a=100, b=7 -> LO=0x0000000E, HI=0x00000002.
- DIVU b=0, a=0x12345678 -> LO=0xFFFFFFFF, HI=0x12345678. DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=0xAAAA0000 via MTHI; start DIV; assert flush_i at iteration 10 -> busy_o low next cycle, HI unchanged, done_o never pulses. A following MTLO 0x5 -> LO=5.
- Drive resetn=0 during the DIV state at iteration 20 -> next cycle state IDLE, hi_o=lo_o=0, stall_o=0.
